// File: rtl/train_sample_feeder_if.sv
// Handshake, load and status signals between the neuron training controller and train_sample_feeder.
// The master drives load/request/rewind; the slave (the feeder) drives the presented sample and status.
interface train_sample_feeder_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 6
) ();
    logic              ld_en;
    logic [DATA_W-1:0] ld_x1;
    logic [DATA_W-1:0] ld_x2;
    logic [DATA_W-1:0] ld_t;
    logic              ld_clear;
    logic              req;
    logic              rewind;
    logic              data_ready;
    logic [DATA_W-1:0] x1;
    logic [DATA_W-1:0] x2;
    logic [DATA_W-1:0] t;
    logic              eof;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic [7:0]        epoch;

    modport master (
        output ld_en, ld_x1, ld_x2, ld_t, ld_clear, req, rewind,
        input  data_ready, x1, x2, t, eof, count, full, empty, epoch
    );

    modport slave (
        input  ld_en, ld_x1, ld_x2, ld_t, ld_clear, req, rewind,
        output data_ready, x1, x2, t, eof, count, full, empty, epoch
    );
endinterface

// File: rtl/train_sample_feeder.sv
// Stores a training set of (x1, x2, t) samples and hands them out one per request, in order,
// flagging the last sample of the set (eof) and counting completed epochs.
module train_sample_feeder #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    train_sample_feeder_if.slave  bus
);
    localparam int unsigned CNT_W    = ADDR_W + 1;
    localparam int unsigned SAMPLE_W = 3 * DATA_W;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] READ    = 2'd1;
    localparam logic [1:0] PRESENT = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [ADDR_W-1:0]   rd_idx;
    logic [CNT_W-1:0]    count_nxt;
    logic [SAMPLE_W-1:0] mem [DEPTH];
    logic                last_c;
    logic                load_c;

    // rd_idx points at the final stored sample
    assign last_c = ({1'b0, rd_idx} == (bus.count - CNT_W'(1)));
    assign load_c = bus.ld_en && !bus.ld_clear && (state == IDLE) && !bus.full;

    always_comb begin
        state_nxt = state;
        count_nxt = bus.count;
        case (state)
            IDLE:    if (bus.req && (bus.count != '0)) state_nxt = READ;
            READ:    state_nxt = PRESENT;
            PRESENT: state_nxt = RELEASE;
            RELEASE: if (!bus.req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Clear abandons any in-flight request
        if (bus.ld_clear) begin
            state_nxt = IDLE;
            count_nxt = '0;
        end else if (load_c) begin
            count_nxt = bus.count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Sample storage has no reset; only entries below count are ever read
    always_ff @(posedge clk) begin
        if (load_c) mem[bus.count[ADDR_W-1:0]] <= {bus.ld_x1, bus.ld_x2, bus.ld_t};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.data_ready <= 1'b0;
            bus.x1         <= '0;
            bus.x2         <= '0;
            bus.t          <= '0;
            bus.eof        <= 1'b0;
            bus.count      <= '0;
            bus.full       <= 1'b0;
            bus.empty      <= 1'b1;
            bus.epoch      <= '0;
            rd_idx         <= '0;
        end else begin
            bus.data_ready <= (state == READ) && !bus.ld_clear;
            bus.count      <= count_nxt;
            bus.full       <= (count_nxt == CNT_W'(DEPTH));
            bus.empty      <= (count_nxt == '0);

            if ((state == READ) && !bus.ld_clear) begin
                {bus.x1, bus.x2, bus.t} <= mem[rd_idx];
            end

            // Clear beats rewind, rewind beats the read-side advance
            if (bus.ld_clear) begin
                rd_idx  <= '0;
                bus.eof <= 1'b0;
                if (bus.rewind) bus.epoch <= bus.epoch + 8'd1;
            end else if (bus.rewind) begin
                rd_idx    <= '0;
                bus.eof   <= 1'b0;
                bus.epoch <= bus.epoch + 8'd1;
            end else if (state == READ) begin
                bus.eof <= last_c;
                rd_idx  <= last_c ? '0 : rd_idx + ADDR_W'(1);
                // eof still set here means the previous epoch ended without a rewind
                if (bus.eof) bus.epoch <= bus.epoch + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_train_sample_feeder.sv
// Randomized scoreboard bench for train_sample_feeder: a queue-based training-set model predicts
// every presentation; a negedge monitor pops and compares whenever data_ready is seen.
module tb_train_sample_feeder;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = 6;

    typedef struct {
        logic [DW-1:0] x1;
        logic [DW-1:0] x2;
        logic [DW-1:0] t;
        logic          eof;
        logic [7:0]    epoch;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    train_sample_feeder_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    train_sample_feeder #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Behavioural model: the training set, the next index, and the epoch bookkeeping
    logic [3*DW-1:0] m_set [$];
    int              m_rd;
    int              m_epoch;
    bit              m_after_eof;
    exp_t            exp_q [$];
    exp_t            mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
        vectors++;
        if (act !== req_v) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req_v, $time);
        end
    endtask

    task automatic model_reset();
        m_set.delete();
        m_rd = 0;
        m_epoch = 0;
        m_after_eof = 1'b0;
    endtask

    // Predict the sample a granted request presents
    task automatic predict(input bit rew);
        exp_t e;
        logic [3*DW-1:0] s;
        bit last;
        s = m_set[m_rd];
        last = (m_rd == m_set.size() - 1);
        e.x1 = s[3*DW-1:2*DW];
        e.x2 = s[2*DW-1:DW];
        e.t  = s[DW-1:0];
        if (rew) begin
            e.eof = 1'b0;
            m_epoch++;
            m_rd = 0;
            m_after_eof = 1'b0;
        end else begin
            e.eof = last;
            if (m_after_eof) m_epoch++;
            m_after_eof = last;
            m_rd = last ? 0 : m_rd + 1;
        end
        e.epoch = 8'(m_epoch);
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.data_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_data_ready: got 1 expected 0 at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("x1", 64'(bus.x1), 64'(mon_e.x1));
                chk("x2", 64'(bus.x2), 64'(mon_e.x2));
                chk("t", 64'(bus.t), 64'(mon_e.t));
                chk("eof", 64'(bus.eof), 64'(mon_e.eof));
                chk("epoch", 64'(bus.epoch), 64'(mon_e.epoch));
            end
        end
    end

    task automatic check_status();
        chk("count", 64'(bus.count), 64'(m_set.size()));
        chk("full", 64'(bus.full), 64'(m_set.size() == DEPTH));
        chk("empty", 64'(bus.empty), 64'(m_set.size() == 0));
    endtask

    task automatic do_load(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
        @(negedge clk);
        bus.ld_en = 1'b1;
        bus.ld_x1 = a;
        bus.ld_x2 = b;
        bus.ld_t  = c;
        if (m_set.size() < DEPTH) m_set.push_back({a, b, c});
        @(negedge clk);
        bus.ld_en = 1'b0;
    endtask

    task automatic do_rewind();
        @(negedge clk);
        bus.rewind = 1'b1;
        m_epoch++;
        m_rd = 0;
        m_after_eof = 1'b0;
        @(negedge clk);
        bus.rewind = 1'b0;
    endtask

    task automatic do_clear(input bit with_ld);
        @(negedge clk);
        bus.ld_clear = 1'b1;
        bus.ld_en    = with_ld;
        bus.ld_x1    = DW'($urandom);
        m_set.delete();
        m_rd = 0;
        m_after_eof = 1'b0;
        @(negedge clk);
        bus.ld_clear = 1'b0;
        bus.ld_en    = 1'b0;
    endtask

    // One request handshake; optionally loads while busy or rewinds on the READ exit edge
    task automatic do_req(input int hold, input bit busy_ld, input bit rew_at_read, input bit keep_req);
        int lat;
        bit granted;
        granted = (m_set.size() != 0);
        @(negedge clk);
        bus.req = 1'b1;
        if (granted) predict(rew_at_read);
        @(negedge clk);
        if (granted && rew_at_read) bus.rewind = 1'b1;
        if (granted && busy_ld) begin
            bus.ld_en = 1'b1;
            bus.ld_x1 = DW'($urandom);
            bus.ld_x2 = DW'($urandom);
            bus.ld_t  = DW'($urandom);
        end
        @(negedge clk);
        bus.rewind = 1'b0;
        lat = 2;
        while (!bus.data_ready && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        if (granted) chk("latency", 64'(lat), 64'd2);
        else         chk("no_data_ready_empty", 64'(bus.data_ready), 64'd0);
        if (!keep_req) begin
            repeat (hold) @(negedge clk);
            bus.ld_en = 1'b0;
            bus.req   = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus.ld_en = 1'b0; bus.ld_x1 = '0; bus.ld_x2 = '0; bus.ld_t = '0;
        bus.ld_clear = 1'b0; bus.req = 1'b0; bus.rewind = 1'b0;
        model_reset();
        #12;
        chk("rst_data_ready", 64'(bus.data_ready), 64'd0);
        chk("rst_x1", 64'(bus.x1), 64'd0);
        chk("rst_x2", 64'(bus.x2), 64'd0);
        chk("rst_t", 64'(bus.t), 64'd0);
        chk("rst_eof", 64'(bus.eof), 64'd0);
        chk("rst_epoch", 64'(bus.epoch), 64'd0);
        check_status();
        @(negedge clk);
        rst = 1'b0;

        // Directed three-sample set, in-order presentation with eof on the last
        do_load(16'd1, 16'd2, 16'd1);
        do_load(16'hFFFD, 16'd4, 16'hFFFF);
        do_load(16'd5, 16'hFFFA, 16'd1);
        check_status();
        do_req(10, 1'b0, 1'b0, 1'b0);
        do_req(0, 1'b0, 1'b0, 1'b0);
        do_req(1, 1'b0, 1'b0, 1'b0);
        do_rewind();
        do_req(0, 1'b0, 1'b0, 1'b0);
        chk("epoch_after_rewind", 64'(bus.epoch), 64'd1);
        do_req(0, 1'b0, 1'b0, 1'b0);
        do_req(0, 1'b0, 1'b0, 1'b0);
        do_req(0, 1'b0, 1'b0, 1'b0);
        chk("epoch_after_wrap", 64'(bus.epoch), 64'd2);

        // Empty set never presents
        do_clear(1'b0);
        check_status();
        @(negedge clk);
        bus.req = 1'b1;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.data_ready) n++;
        end
        bus.req = 1'b0;
        chk("empty_req_pulses", 64'(n), 64'd0);

        // Fill to capacity, overflow and busy loads are dropped
        for (int i = 0; i < DEPTH + 1; i++) do_load(DW'($urandom), DW'($urandom), DW'($urandom));
        check_status();
        do_req(3, 1'b1, 1'b0, 1'b0);
        do_clear(1'b0);
        for (int i = 0; i < 4; i++) do_load(DW'($urandom), DW'($urandom), DW'($urandom));
        do_req(2, 1'b1, 1'b0, 1'b0);
        check_status();
        do_req(0, 1'b0, 1'b1, 1'b0);
        do_req(0, 1'b0, 1'b0, 1'b0);

        // Randomized mix of operations
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: do_req(int'($urandom_range(0, 3)), (m_set.size() != 0) && $urandom_range(0, 1) == 1,
                                      (m_set.size() != 0) && !m_after_eof && $urandom_range(0, 3) == 0, 1'b0);
                5, 6: if (m_set.size() < DEPTH) do_load(DW'($urandom), DW'($urandom), DW'($urandom));
                7: do_rewind();
                8: repeat ($urandom_range(1, 5)) do_load(DW'($urandom), DW'($urandom), DW'($urandom));
                default: if ($urandom_range(0, 3) == 0) do_clear($urandom_range(0, 1) == 1);
            endcase
            if (i % 20 == 0) check_status();
        end

        // Clear during READ abandons the request
        if (m_set.size() == 0) do_load(16'd7, 16'd8, 16'd9);
        @(negedge clk);
        bus.req = 1'b1;
        @(negedge clk);
        bus.ld_clear = 1'b1;
        m_set.delete();
        m_rd = 0;
        m_after_eof = 1'b0;
        @(negedge clk);
        bus.ld_clear = 1'b0;
        n = 0;
        repeat (4) begin
            if (bus.data_ready) n++;
            @(negedge clk);
        end
        bus.req = 1'b0;
        chk("clear_in_read_pulses", 64'(n), 64'd0);
        check_status();
        do_load(16'd3, 16'd3, 16'd3);
        do_clear(1'b1);
        check_status();

        // Async reset in the middle of PRESENT
        do_load(16'h1234, 16'h5678, 16'h9ABC);
        do_req(0, 1'b0, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_data_ready", 64'(bus.data_ready), 64'd0);
        chk("arst_x1", 64'(bus.x1), 64'd0);
        chk("arst_x2", 64'(bus.x2), 64'd0);
        chk("arst_t", 64'(bus.t), 64'd0);
        chk("arst_eof", 64'(bus.eof), 64'd0);
        chk("arst_count", 64'(bus.count), 64'd0);
        chk("arst_epoch", 64'(bus.epoch), 64'd0);
        bus.req = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("pending_expectations", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
